cpu_ifu_bht: RTL and testbench

Parametrised instruction-fetch unit with a dynamic branch predictor. It generates the fetch PC for the program memory and decodes the returned instruction for JAL/JALR/BRANCH. Conditional branches are predicted from a table of saturating counters that the execute stage trains through an update port. It sits between the program memory and the decode stage, and the execute stage redirects it on a misprediction.

---
 rtl/cpu_ifu_bht.sv | 125 ++++++++++++
 tb/tb_cpu_ifu_bht.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_ifu_bht.sv
// Fetch-PC generator with JAL/JALR/BRANCH decode and zero-bubble redirect; pc is combinational, pc_now registered.
// Define BHT_EN to build the trainable saturating-counter BHT; otherwise branches use static backward-taken.
module cpu_ifu_bht #(
  parameter int PC_W      = 16,
  parameter int BHT_DEPTH = 64,
  parameter int CNT_W     = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            running,
  input  logic            flush_flag,
  input  logic [PC_W-1:0] flush_pc,
  input  logic            wait_exe,
  input  logic            wait_jmp,
  input  logic [31:0]     instruction,
  input  logic [31:0]     jmp_data,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  output logic            jmp_pred,
  output logic            jmp_reg_en,
  output logic [4:0]      jmp_rs,
  output logic [PC_W-1:0] pc_now,
  output logic [PC_W-1:0] pc
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic            r_running_d;
  logic            w_pc_move;
  logic [6:0]      w_opcode;
  logic            w_is_jal;
  logic            w_is_jalr;
  logic            w_is_br;
  logic [31:0]     w_imm_j;
  logic [31:0]     w_imm_i;
  logic [31:0]     w_imm_b;
  logic [31:0]     w_imm;
  logic [31:0]     w_pc_now32;
  logic [PC_W-1:0] w_pc_jmp;
  logic            w_br_taken;
  logic            w_pred_raw;

  assign w_pc_move = running & r_running_d;

  assign w_opcode  = instruction[6:0];
  assign w_is_jal  = (w_opcode == OP_JAL);
  assign w_is_jalr = (w_opcode == OP_JALR);
  assign w_is_br   = (w_opcode == OP_BRANCH);

  assign w_imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                    instruction[20], instruction[30:21], 1'b0};
  assign w_imm_i = {{20{instruction[31]}}, instruction[31:20]};
  assign w_imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                    instruction[30:25], instruction[11:8], 1'b0};

  always_comb begin
    w_imm = '0;
    if (w_is_jal)       w_imm = w_imm_j;
    else if (w_is_jalr) w_imm = w_imm_i;
    else if (w_is_br)   w_imm = w_imm_b;
  end

  // Target is formed at 32 bits and truncated, so wrap is modulo 2^PC_W.
  assign w_pc_now32 = 32'(pc_now);
  assign w_pc_jmp   = w_is_jalr ? PC_W'((jmp_data + w_imm) & ~32'd1)
                                : PC_W'(w_pc_now32 + w_imm);

`ifdef BHT_EN
  localparam logic [CNT_W-1:0] CNT_RST = {1'b0, {(CNT_W-1){1'b1}}};

  logic [CNT_W-1:0] r_cnt [BHT_DEPTH];
  logic [IDX_W-1:0] w_rd_idx;
  logic [IDX_W-1:0] w_upd_idx;

  assign w_rd_idx  = pc_now[IDX_W+1:2];
  assign w_upd_idx = upd_pc[IDX_W+1:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) r_cnt[i] <= CNT_RST;
    end else if (upd_valid) begin
      if (upd_taken && (r_cnt[w_upd_idx] != '1))
        r_cnt[w_upd_idx] <= r_cnt[w_upd_idx] + CNT_W'(1);
      else if (!upd_taken && (r_cnt[w_upd_idx] != '0))
        r_cnt[w_upd_idx] <= r_cnt[w_upd_idx] - CNT_W'(1);
    end
  end

  // Read sees the registered value, so a same-cycle update is not yet visible.
  assign w_br_taken = r_cnt[w_rd_idx][CNT_W-1];
`else
  logic w_unused_upd;
  assign w_unused_upd = ^{upd_valid, upd_pc, upd_taken};
  assign w_br_taken   = w_imm_b[31];
`endif

  assign w_pred_raw = w_is_jal | w_is_jalr | (w_is_br & w_br_taken);
  assign jmp_pred   = w_pred_raw & ~flush_flag & w_pc_move;
  assign jmp_reg_en = w_is_jalr;
  assign jmp_rs     = instruction[19:15];

  always_comb begin
    pc = pc_now + PC_W'(4);
    if (!w_pc_move)                pc = pc_now;
    else if (flush_flag)           pc = flush_pc;
    else if (wait_exe || wait_jmp) pc = pc_now;
    else if (jmp_pred)             pc = w_pc_jmp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_running_d <= 1'b0;
      pc_now      <= '0;
    end else begin
      r_running_d <= running;
      if (w_pc_move) pc_now <= pc;
    end
  end

endmodule

// File: tb/tb_cpu_ifu_bht.sv
// Scoreboard bench: stimulus pushes model-predicted outputs, a negedge monitor pops and compares.
module tb_cpu_ifu_bht;
  localparam int PC_W      = 16;
  localparam int BHT_DEPTH = 64;
  localparam int CNT_W     = 2;
`ifdef BHT_EN
  localparam bit BHT = 1'b1;
`else
  localparam bit BHT = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            running = 1'b0;
  logic            flush_flag = 1'b0;
  logic [PC_W-1:0] flush_pc = '0;
  logic            wait_exe = 1'b0;
  logic            wait_jmp = 1'b0;
  logic [31:0]     instruction = 32'h13;
  logic [31:0]     jmp_data = '0;
  logic            upd_valid = 1'b0;
  logic [PC_W-1:0] upd_pc = '0;
  logic            upd_taken = 1'b0;
  logic            jmp_pred;
  logic            jmp_reg_en;
  logic [4:0]      jmp_rs;
  logic [PC_W-1:0] pc_now;
  logic [PC_W-1:0] pc;

  cpu_ifu_bht #(.PC_W(PC_W), .BHT_DEPTH(BHT_DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .running(running), .flush_flag(flush_flag),
    .flush_pc(flush_pc), .wait_exe(wait_exe), .wait_jmp(wait_jmp),
    .instruction(instruction), .jmp_data(jmp_data), .upd_valid(upd_valid),
    .upd_pc(upd_pc), .upd_taken(upd_taken), .jmp_pred(jmp_pred),
    .jmp_reg_en(jmp_reg_en), .jmp_rs(jmp_rs), .pc_now(pc_now), .pc(pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          run, flush, we, wj, uv, ut;
    logic [15:0] fpc, upc;
    int          kind;   // 0 other, 1 JAL, 2 JALR, 3 BRANCH
    int          imm;
    logic [31:0] jd;
  } stim_t;

  typedef struct {
    logic [15:0] pc, pc_now;
    logic        pred, reg_en;
    logic [4:0]  rs;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  int m_pc_now;
  bit m_run_d;
  int m_cnt [BHT_DEPTH];

  function automatic void model_reset();
    m_pc_now = 0;
    m_run_d  = 1'b0;
    for (int i = 0; i < BHT_DEPTH; i++) m_cnt[i] = (1 << (CNT_W-1)) - 1;
  endfunction

  function automatic stim_t nop();
    stim_t s;
    s.run = 1; s.flush = 0; s.we = 0; s.wj = 0; s.uv = 0; s.ut = 0;
    s.fpc = '0; s.upc = '0; s.kind = 0; s.imm = 0; s.jd = '0;
    return s;
  endfunction

  function automatic logic [31:0] enc(input int kind, input int imm);
    logic [31:0] u, r;
    logic [6:0]  op;
    u = imm;
    r = $urandom;
    case (kind)
      1: return {u[20], u[10:1], u[11], u[19:12], r[11:7], 7'h6f};
      2: return {u[11:0], r[19:15], 3'b000, r[11:7], 7'h67};
      3: return {u[12], u[10:5], r[24:20], r[19:15], r[14:12], u[4:1], u[11], 7'h63};
      default: begin
        op = r[6:0];
        if (op == 7'h6f || op == 7'h67 || op == 7'h63) op = 7'h13;
        return {r[31:7], op};
      end
    endcase
  endfunction

  task automatic step(input stim_t s);
    exp_t        e;
    logic [31:0] ins;
    bit          move, pred;
    int          idx, nxt, iu, cmax;
    longint      tgt;
    ins  = enc(s.kind, s.imm);
    move = s.run && m_run_d;
    idx  = (m_pc_now / 4) % BHT_DEPTH;
    case (s.kind)
      1, 2:    pred = 1;
      3:       pred = BHT ? (m_cnt[idx] >= (1 << (CNT_W-1))) : (s.imm < 0);
      default: pred = 0;
    endcase
    if (s.kind == 2) tgt = (longint'(s.jd) + s.imm) & 64'hFFFE;
    else             tgt = (longint'(m_pc_now) + s.imm) & 64'hFFFF;
    if (!move)               nxt = m_pc_now;
    else if (s.flush)        nxt = int'(s.fpc);
    else if (s.we || s.wj)   nxt = m_pc_now;
    else if (pred)           nxt = int'(tgt);
    else                     nxt = (m_pc_now + 4) % 65536;
    e.pc     = nxt[15:0];
    e.pc_now = m_pc_now[15:0];
    e.pred   = pred && !s.flush && move;
    e.reg_en = (s.kind == 2);
    e.rs     = ins[19:15];
    exp_q.push_back(e);
    running = s.run; flush_flag = s.flush; flush_pc = s.fpc;
    wait_exe = s.we; wait_jmp = s.wj; instruction = ins; jmp_data = s.jd;
    upd_valid = s.uv; upd_pc = s.upc; upd_taken = s.ut;
    if (move) m_pc_now = nxt;
    m_run_d = s.run;
    if (BHT && s.uv) begin
      iu   = (int'(s.upc) / 4) % BHT_DEPTH;
      cmax = (1 << CNT_W) - 1;
      if (s.ut) m_cnt[iu] = (m_cnt[iu] < cmax) ? m_cnt[iu] + 1 : cmax;
      else      m_cnt[iu] = (m_cnt[iu] > 0) ? m_cnt[iu] - 1 : 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #2;
    rst_n = 1'b1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pc",         32'(pc),         32'(e.pc));
      chk("pc_now",     32'(pc_now),     32'(e.pc_now));
      chk("jmp_pred",   32'(jmp_pred),   32'(e.pred));
      chk("jmp_reg_en", 32'(jmp_reg_en), 32'(e.reg_en));
      chk("jmp_rs",     32'(jmp_rs),     32'(e.rs));
    end
  end

  initial begin
    stim_t s;
    int    x;
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // reset state, then fetch start from NOP stream
    s = nop(); s.run = 0; step(s); step(s);
    s = nop(); repeat (3) step(s);
    s.kind = 1; s.imm = 16; step(s);
    s = nop(); step(s);

    // JALR target with bit0 cleared
    s = nop(); s.kind = 2; s.imm = 4; s.jd = 32'h1003; step(s);
    s = nop(); step(s);

    // forward branch at 0x40: train taken under stall, then train not-taken
    s = nop(); s.flush = 1; s.fpc = 16'h40; step(s);
    s = nop(); s.kind = 3; s.imm = 8; s.we = 1; step(s);
    s.uv = 1; s.upc = 16'h40; s.ut = 1; step(s); step(s);
    s.uv = 0; s.we = 0; step(s);
    s = nop(); s.flush = 1; s.fpc = 16'h40; step(s);
    s = nop(); s.kind = 3; s.imm = 8; s.we = 1; s.uv = 1; s.upc = 16'h40; s.ut = 0;
    repeat (4) step(s);
    s.uv = 0; s.we = 0; step(s);

    // backward branch at 0x80
    s = nop(); s.flush = 1; s.fpc = 16'h80; step(s);
    s = nop(); s.kind = 3; s.imm = -16; step(s);
    s = nop(); step(s);

    // flush beats stall and JAL
    s = nop(); s.kind = 1; s.imm = 16; s.flush = 1; s.fpc = 16'h200; s.we = 1; step(s);
    s = nop(); s.kind = 2; s.imm = 8; s.jd = 32'h3000; s.wj = 1; repeat (3) step(s);
    s.wj = 0; step(s);

    // running pause and resume
    s = nop(); s.run = 0; repeat (2) step(s);
    s = nop(); repeat (2) step(s);

    // reset mid-operation clears trained counters
    s = nop(); s.uv = 1; s.upc = 16'h40; s.ut = 1; repeat (3) step(s);
    do_reset();
    s = nop(); step(s);
    s.flush = 1; s.fpc = 16'h40; step(s);
    s = nop(); s.kind = 3; s.imm = 8; s.we = 1; step(s);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      s = nop();
      s.run   = ($urandom_range(0, 9) != 0);
      s.flush = ($urandom_range(0, 11) == 0);
      s.fpc   = 16'($urandom_range(0, 16383) * 4);
      s.we    = ($urandom_range(0, 9) == 0);
      s.wj    = ($urandom_range(0, 11) == 0);
      s.uv    = ($urandom_range(0, 2) == 0);
      s.upc   = 16'($urandom_range(0, 255) * 4);
      s.ut    = $urandom_range(0, 1);
      s.jd    = $urandom;
      s.kind  = $urandom_range(0, 3);
      x = $urandom;
      case (s.kind)
        1: s.imm = ((x <<< 11) >>> 11) & ~1;
        2: s.imm = (x <<< 20) >>> 20;
        3: s.imm = ((x <<< 19) >>> 19) & ~1;
        default: s.imm = 0;
      endcase
      step(s);
      if (n == 300) do_reset();
    end

    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
